uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares the UART's single transmit path between N_REQ byte-stream requesters, e.g. the boot monitor, a hardware trace unit and a debug console.
- Sole master of the UART's register port: polls the status register for transmit-queue space, then writes granted bytes to the data register.
- Optional packet locking keeps multi-byte messages from interleaving.
- Never writes the UART status register, so software-owned txc, rx_en, rxc and rx_err are never disturbed.

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART register-port bundle for the transmit arbiter.
// master = arbiter side, slave = requesters plus UART side.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   grant;
    logic               uart_write_en;
    logic               uart_addr;
    logic [31:0]        uart_write_val;
    logic [31:0]        uart_read_val;
    logic               busy;

    modport master (
        input  req_valid, req_data, req_last, uart_read_val,
        output req_ready, grant, uart_write_en, uart_addr, uart_write_val, busy
    );

    modport slave (
        output req_valid, req_data, req_last, uart_read_val,
        input  req_ready, grant, uart_write_en, uart_addr, uart_write_val, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path between N_REQ byte streams.
// Polls the UART status register for queue space, then writes the granted byte.
module uart_tx_arbiter #(
    parameter int N_REQ        = 2,
    parameter int LOCK_PACKETS = 1,
    parameter int MAX_BURST    = 16
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.master  bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, POLL, WRITE, SETTLE} state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_owner, w_owner_nxt;
    logic [PW-1:0] r_ptr, w_ptr_nxt;
    logic [7:0]    r_burst, w_burst_nxt;
    logic          r_last, w_last_nxt;

    logic [PW-1:0] w_idx [N_REQ];
    logic [7:0]    w_data [N_REQ];
    logic [PW-1:0] w_pick, w_owner_inc;
    logic          w_found, w_own_valid;
    logic [7:0]    w_own_data, w_burst_inc;
    logic          w_unused;

    // Search order starting at rr_ptr with wrap-around, plus per-lane byte view.
    for (genvar k = 0; k < N_REQ; k++) begin : g_lane
        assign w_idx[k]  = PW'((k + int'(r_ptr)) % N_REQ);
        assign w_data[k] = bus.req_data[8*k +: 8];
    end

    assign w_own_valid = bus.req_valid[r_owner];
    assign w_own_data  = w_data[r_owner];
    assign w_owner_inc = (int'(r_owner) == N_REQ - 1) ? '0 : r_owner + 1'b1;
    assign w_burst_inc = r_burst + 8'd1;
    assign w_unused    = ^{bus.uart_read_val[31:2], bus.uart_read_val[0]};

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[w_idx[k]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_burst <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_burst <= w_burst_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_burst_nxt = r_burst;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_owner_nxt = w_pick;
                    w_burst_nxt = '0;
                    w_state_nxt = POLL;
                end
            end
            POLL: begin
                if (bus.uart_read_val[1] && w_own_valid) begin
                    w_state_nxt = WRITE;
                end else if (LOCK_PACKETS == 0 && !w_own_valid) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = w_owner_inc;
                end
            end
            WRITE: begin
                w_burst_nxt = w_burst_inc;
                w_last_nxt  = bus.req_last[r_owner] || (LOCK_PACKETS == 0) ||
                              (MAX_BURST != 0 && w_burst_inc == 8'(MAX_BURST));
                w_state_nxt = SETTLE;
            end
            SETTLE: begin
                // Status is stale this cycle: the UART updates its full flag one cycle late.
                if (r_last) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = w_owner_inc;
                end else begin
                    w_state_nxt = POLL;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.grant          = '0;
        bus.req_ready      = '0;
        bus.uart_write_en  = 1'b0;
        bus.uart_addr      = 1'b1;
        bus.uart_write_val = '0;
        bus.busy           = (r_state != IDLE);
        if (r_state != IDLE) bus.grant[r_owner] = 1'b1;
        if (r_state == WRITE) begin
            bus.uart_write_en     = 1'b1;
            bus.uart_addr         = 1'b0;
            bus.uart_write_val    = {24'b0, w_own_data};
            bus.req_ready[r_owner] = 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench: two arbiter instances (locked with burst limit 4, unlocked with 3 requesters)
// driven from per-requester byte queues and checked against a tenure-level model.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(2)) if_a();
    uart_tx_arbiter_if #(.N_REQ(3)) if_b();

    uart_tx_arbiter #(.N_REQ(2), .LOCK_PACKETS(1), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.master));
    uart_tx_arbiter #(.N_REQ(3), .LOCK_PACKETS(0), .MAX_BURST(0)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.master));

    typedef struct {
        logic        we;
        logic        addr;
        logic [31:0] val;
        logic [2:0]  rdy;
        logic [2:0]  gnt;
        logic        busy;
    } obs_t;

    int total = 0;
    int bad   = 0;

    logic [8:0] mem [2][3][64];   // {last, data}
    int         hd [2][3];
    int         tl [2][3];
    int         er [2][64];
    logic [7:0] ed [2][64];
    int         ecnt [2];
    int         lr [2][64];
    logic [7:0] ld [2][64];
    int         lcnt [2];
    int         mptr [2];
    int         full_pct [2];
    logic       st_ok [2];
    logic [2:0] rdy_prev [2];

    function automatic int nreq(int d); return (d == 0) ? 2 : 3; endfunction
    function automatic bit lock(int d); return (d == 0); endfunction
    function automatic int mb(int d); return (d == 0) ? 4 : 0; endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic obs_t get_obs(int d);
        obs_t o;
        if (d == 0) begin
            o.we = if_a.uart_write_en; o.addr = if_a.uart_addr; o.val = if_a.uart_write_val;
            o.rdy = {1'b0, if_a.req_ready}; o.gnt = {1'b0, if_a.grant}; o.busy = if_a.busy;
        end else begin
            o.we = if_b.uart_write_en; o.addr = if_b.uart_addr; o.val = if_b.uart_write_val;
            o.rdy = if_b.req_ready; o.gnt = if_b.grant; o.busy = if_b.busy;
        end
        return o;
    endfunction

    task automatic push(int d, int r, logic last, logic [7:0] data);
        mem[d][r][tl[d][r]] = {last, data};
        tl[d][r]++;
    endtask

    task automatic apply();
        for (int d = 0; d < 2; d++) begin
            logic [31:0] rv;
            rv = $urandom;
            st_ok[d] = (int'($urandom_range(99)) >= full_pct[d]);
            rv[1] = st_ok[d];
            if (d == 0) if_a.uart_read_val = rv; else if_b.uart_read_val = rv;
            for (int r = 0; r < nreq(d); r++) begin
                logic       v;
                logic [8:0] w;
                v = hd[d][r] < tl[d][r];
                w = v ? mem[d][r][hd[d][r]] : {1'b0, 8'($urandom)};
                if (d == 0) begin
                    if_a.req_valid[r] = v; if_a.req_data[8*r +: 8] = w[7:0]; if_a.req_last[r] = w[8];
                end else begin
                    if_b.req_valid[r] = v; if_b.req_data[8*r +: 8] = w[7:0]; if_b.req_last[r] = w[8];
                end
            end
        end
    endtask

    // One cycle: retire bytes accepted at the last edge, check bus rules, then drive.
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            obs_t o;
            logic ok;
            for (int r = 0; r < nreq(d); r++)
                if (rdy_prev[d][r] && hd[d][r] < tl[d][r]) hd[d][r]++;
            o = get_obs(d);
            if (o.we)
                ok = (o.addr === 1'b0) && (o.val[31:8] === 24'd0) && (o.rdy === o.gnt) &&
                     $onehot(o.gnt) && st_ok[d];
            else
                ok = (o.addr === 1'b1) && (o.val === 32'd0) && (o.rdy === 3'd0);
            chk($sformatf("bus_rules_%0d", d), {31'd0, ok}, 32'd1);
            chk($sformatf("busy_%0d", d), {31'd0, o.busy}, {31'd0, (o.gnt != 3'd0)});
            chk($sformatf("grant_onehot0_%0d", d), {31'd0, $onehot0(o.gnt)}, 32'd1);
            if (o.we && lcnt[d] < 64) begin
                for (int r = 0; r < 3; r++) if (o.rdy[r]) lr[d][lcnt[d]] = r;
                ld[d][lcnt[d]] = o.val[7:0];
                lcnt[d]++;
            end
            rdy_prev[d] = o.rdy;
        end
        apply();
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = !if_a.busy && !if_b.busy;
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < nreq(d); r++)
                if (hd[d][r] < tl[d][r]) idle = 0;
        return idle;
    endfunction

    task automatic drain(int budget);
        int n = 0;
        while (n < budget && !all_idle()) begin step(); n++; end
        chk("drain_done", {31'd0, all_idle()}, 32'd1);
    endtask

    task automatic begin_scn();
        for (int d = 0; d < 2; d++) begin
            lcnt[d] = 0;
            ecnt[d] = 0;
            for (int r = 0; r < 3; r++)
                if (hd[d][r] >= tl[d][r]) begin hd[d][r] = 0; tl[d][r] = 0; end
        end
    endtask

    // Reference: tenures served round-robin from the queued bytes.
    task automatic build(int d);
        int h[3];
        int n;
        int o, cnt, idx;
        logic [8:0] w;
        bit stop;
        n = nreq(d);
        for (int r = 0; r < 3; r++) h[r] = hd[d][r];
        ecnt[d] = 0;
        for (int t = 0; t < 200; t++) begin
            o = -1;
            for (int k = n - 1; k >= 0; k--) begin
                idx = (mptr[d] + k) % n;
                if (h[idx] < tl[d][idx]) o = idx;
            end
            if (o < 0) break;
            cnt  = 0;
            stop = 0;
            while (!stop) begin
                w = mem[d][o][h[o]];
                h[o]++;
                cnt++;
                er[d][ecnt[d]] = o;
                ed[d][ecnt[d]] = w[7:0];
                ecnt[d]++;
                stop = !lock(d) || w[8] || (mb(d) != 0 && cnt == mb(d)) || (h[o] == tl[d][o]);
            end
            mptr[d] = (o + 1) % n;
        end
    endtask

    task automatic cmp_log(int d, string tag);
        chk({tag, "_count"}, lcnt[d], ecnt[d]);
        for (int k = 0; k < ecnt[d] && k < lcnt[d]; k++) begin
            chk($sformatf("%s_req%0d", tag, k), lr[d][k], er[d][k]);
            chk($sformatf("%s_dat%0d", tag, k), {24'd0, ld[d][k]}, {24'd0, ed[d][k]});
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 3; r++) begin hd[d][r] = 0; tl[d][r] = 0; end
            lcnt[d] = 0; ecnt[d] = 0; mptr[d] = 0; full_pct[d] = 0; rdy_prev[d] = '0;
        end
        if_a.req_valid = '0; if_a.req_data = '0; if_a.req_last = '0;
        if_b.req_valid = '0; if_b.req_data = '0; if_b.req_last = '0;
        apply();

        // Reset state
        step(); step();
        chk("rst_grant", {30'd0, if_a.grant}, 32'd0);
        chk("rst_busy", {31'd0, if_a.busy}, 32'd0);
        chk("rst_addr", {31'd0, if_a.uart_addr}, 32'd1);
        chk("rst_we", {31'd0, if_a.uart_write_en}, 32'd0);
        chk("rst_wval", if_a.uart_write_val, 32'd0);
        chk("rst_ready_b", {29'd0, if_b.req_ready}, 32'd0);
        rst = 1'b0;
        step();

        // Single byte: write two edges after valid, grant clears two cycles after the write
        begin_scn();
        push(0, 0, 1'b1, 8'h41);
        build(0);
        apply();
        step();
        chk("single_poll_grant", {30'd0, if_a.grant}, 32'd1);
        chk("single_poll_we", {31'd0, if_a.uart_write_en}, 32'd0);
        step();
        chk("single_we", {31'd0, if_a.uart_write_en}, 32'd1);
        chk("single_addr", {31'd0, if_a.uart_addr}, 32'd0);
        chk("single_wval", if_a.uart_write_val, 32'h41);
        chk("single_ready", {30'd0, if_a.req_ready}, 32'd1);
        step();
        chk("single_settle_grant", {30'd0, if_a.grant}, 32'd1);
        step();
        chk("single_release_grant", {30'd0, if_a.grant}, 32'd0);
        chk("single_release_busy", {31'd0, if_a.busy}, 32'd0);
        cmp_log(0, "single");

        // UART queue full: hold off for 50 cycles
        begin_scn();
        full_pct[0] = 100;
        push(0, 1, 1'b1, 8'h55);
        build(0);
        apply();
        repeat (50) step();
        chk("qfull_nowrite", lcnt[0], 32'd0);
        chk("qfull_grant", {30'd0, if_a.grant}, 32'd2);
        chk("qfull_busy", {31'd0, if_a.busy}, 32'd1);
        full_pct[0] = 0;
        apply();
        for (int n = 0; n < 2 && lcnt[0] == 0; n++) step();
        chk("qfull_release_write", lcnt[0], 32'd1);
        drain(100);
        cmp_log(0, "qfull");

        // Round robin, single-byte packets
        begin_scn();
        full_pct[0] = 30;
        for (int i = 0; i < 4; i++) begin push(0, 0, 1'b1, 8'h30); push(0, 1, 1'b1, 8'h31); end
        build(0);
        apply();
        drain(500);
        cmp_log(0, "rr");

        // Packet lock (dut_a) against per-byte release (dut_b)
        begin_scn();
        full_pct[0] = 0; full_pct[1] = 0;
        for (int d = 0; d < 2; d++) begin
            push(d, 0, 1'b0, 8'h48); push(d, 0, 1'b0, 8'h69); push(d, 0, 1'b1, 8'h0A);
            push(d, 1, 1'b1, 8'h77); push(d, 1, 1'b1, 8'h78);
            build(d);
        end
        apply();
        drain(500);
        chk("lock_third_from_req0", lr[0][2], 32'd0);
        chk("nolock_second_from_req1", lr[1][1], 32'd1);
        cmp_log(0, "lock");
        cmp_log(1, "nolock");

        // Burst limit of 4 breaks a long packet
        begin_scn();
        for (int i = 0; i < 10; i++) push(0, 0, (i == 9), 8'(8'hA0 + i));
        push(0, 1, 1'b1, 8'h5B);
        build(0);
        apply();
        drain(500);
        chk("burst_fifth_is_req1", lr[0][4], 32'd1);
        cmp_log(0, "burst");

        // Random packets and UART back-pressure
        for (int round = 0; round < 6; round++) begin
            begin_scn();
            for (int d = 0; d < 2; d++) begin
                full_pct[d] = $urandom_range(60);
                for (int r = 0; r < nreq(d); r++) begin
                    int len;
                    len = $urandom_range(8);
                    for (int i = 0; i < len; i++)
                        push(d, r, (i == len - 1) || ($urandom_range(3) == 0), 8'($urandom));
                end
                build(d);
            end
            apply();
            drain(3000);
            cmp_log(0, $sformatf("rnd%0d_a", round));
            cmp_log(1, $sformatf("rnd%0d_b", round));
        end

        // Reset while the owner waits in POLL
        begin_scn();
        full_pct[0] = 100;
        push(0, 0, 1'b1, 8'h99);
        apply();
        step(); step();
        chk("rstpoll_grant_before", {30'd0, if_a.grant}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstpoll_grant", {30'd0, if_a.grant}, 32'd0);
        chk("rstpoll_busy", {31'd0, if_a.busy}, 32'd0);
        chk("rstpoll_we", {31'd0, if_a.uart_write_en}, 32'd0);
        mptr[0] = 0; mptr[1] = 0;
        step(); step();
        chk("rstpoll_no_accept", hd[0][0], 32'd0);
        push(0, 1, 1'b1, 8'hAA);
        full_pct[0] = 0;
        lcnt[0] = 0;
        build(0);
        apply();
        rst = 1'b0;
        step();
        chk("rstpoll_first_grant", {30'd0, if_a.grant}, 32'd1);
        drain(200);
        cmp_log(0, "rstpoll");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
